// File: rtl/rv_buf_pkg.sv
// Shared sizing helpers for the rv_* ready/valid block family.
// rv_buf_cw gives the occupancy counter width, rv_buf_pw the storage pointer width.
package rv_buf_pkg;

    function automatic int rv_buf_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single-entry range still needs one pointer bit.
    function automatic int rv_buf_pw(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rv_buf_ptr.sv
// Wrapping storage pointer for rv_elastic_buffer; counts 0..DEPTH-1 and wraps
// explicitly, so DEPTH does not have to be a power of two.
module rv_buf_ptr
    import rv_buf_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = rv_buf_pw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rv_elastic_buffer.sv
// DEPTH-entry ready/valid elastic buffer with registered in_ready/out_valid.
// Define RV_ELASTIC_BUF_LEVEL_EN to expose the registered occupancy on the level port.
module rv_elastic_buffer
    import rv_buf_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CW    = rv_buf_cw(DEPTH),
    localparam int PW    = rv_buf_pw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef RV_ELASTIC_BUF_LEVEL_EN
    ,
    output logic [CW-1:0]    level
`endif
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             push;
    logic             pop;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Ready only looks at the registered flag, so a full buffer refuses a push
    // even in the cycle it is being popped.
    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    rv_buf_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .ptr (wr_ptr)
    );

    rv_buf_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        in_ready_d  = (count_d != CW'(DEPTH));
        out_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // NOTE: storage is deliberately not reset; out_valid qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = mem[rd_ptr];

`ifdef RV_ELASTIC_BUF_LEVEL_EN
    assign level = count_q;
`endif

endmodule

// File: tb/tb_rv_elastic_buffer.sv
// Bench for rv_elastic_buffer: three instances (DEPTH 2, 5, 3) scored every cycle
// against a queue model built from head/tail indices; level checked when RV_ELASTIC_BUF_LEVEL_EN is set.
module tb_rv_elastic_buffer;

    localparam int N  = 3;
    localparam int SB = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [N-1:0] iv;
    logic [N-1:0] orr;
    wire  [N-1:0] ir;
    wire  [N-1:0] ov;
    logic [7:0]   id [N];
    wire  [7:0]   od0, od1, od2;
`ifdef RV_ELASTIC_BUF_LEVEL_EN
    wire  [1:0]   lv0;
    wire  [2:0]   lv1;
    wire  [1:0]   lv2;
`endif

    rv_elastic_buffer #(.WIDTH(8), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od0)
`ifdef RV_ELASTIC_BUF_LEVEL_EN
        , .level(lv0)
`endif
    );

    rv_elastic_buffer #(.WIDTH(8), .DEPTH(5)) u_d5 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od1)
`ifdef RV_ELASTIC_BUF_LEVEL_EN
        , .level(lv1)
`endif
    );

    rv_elastic_buffer #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od2)
`ifdef RV_ELASTIC_BUF_LEVEL_EN
        , .level(lv2)
`endif
    );

    // Reference model: per-instance FIFO of accepted beats, head/tail indices.
    logic [7:0] sb [N][SB];
    int hd [N];
    int tl [N];
    int pushes [N];
    int pops [N];
    int n_tests;
    int n_fail;

    function automatic int dep_of(input int i);
        case (i)
            0:       return 2;
            1:       return 5;
            default: return 3;
        endcase
    endfunction

    function automatic logic [7:0] od_of(input int i);
        case (i)
            0:       return od0;
            1:       return od1;
            default: return od2;
        endcase
    endfunction

`ifdef RV_ELASTIC_BUF_LEVEL_EN
    function automatic logic [31:0] lv_of(input int i);
        case (i)
            0:       return 32'(lv0);
            1:       return 32'(lv1);
            default: return 32'(lv2);
        endcase
    endfunction
`endif

    // One clock: score outputs at the falling edge, then advance the model on the rising edge.
    task automatic tick();
        bit [N-1:0] do_push;
        bit [N-1:0] do_pop;
        logic [7:0] cap [N];
        int cnt;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            cnt = tl[i] - hd[i];
            n_tests++;
            if (ir[i] !== (cnt != dep_of(i))) begin
                n_fail++;
                $display("FAIL sb_in_ready[%0d] t=%0t: got %b want %b", i, $time, ir[i], cnt != dep_of(i));
            end
            n_tests++;
            if (ov[i] !== (cnt != 0)) begin
                n_fail++;
                $display("FAIL sb_out_valid[%0d] t=%0t: got %b want %b", i, $time, ov[i], cnt != 0);
            end
            if (cnt != 0) begin
                n_tests++;
                if (od_of(i) !== sb[i][hd[i] % SB]) begin
                    n_fail++;
                    $display("FAIL sb_out_data[%0d] t=%0t: got %h want %h", i, $time, od_of(i), sb[i][hd[i] % SB]);
                end
            end
`ifdef RV_ELASTIC_BUF_LEVEL_EN
            n_tests++;
            if (lv_of(i) !== 32'(cnt)) begin
                n_fail++;
                $display("FAIL sb_level[%0d] t=%0t: got %0d want %0d", i, $time, lv_of(i), cnt);
            end
`endif
            do_push[i] = iv[i] && (cnt != dep_of(i));
            do_pop[i]  = orr[i] && (cnt != 0);
            cap[i]     = id[i];
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                hd[i] = tl[i];
            end else begin
                if (do_pop[i]) begin
                    hd[i]++;
                    pops[i]++;
                end
                if (do_push[i]) begin
                    sb[i][tl[i] % SB] = cap[i];
                    tl[i]++;
                    pushes[i]++;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        iv  = '0;
        orr = '0;
        for (int i = 0; i < N; i++) id[i] = 8'($urandom);
    endtask

    task automatic drain(input int cycles);
        iv  = '0;
        orr = '1;
        repeat (cycles) tick();
        orr = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (ir !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 111", ir);
        end
        n_tests++;
        if (ov !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 000", ov);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        iv = '1;
        repeat (3) begin
            for (int i = 0; i < N; i++) id[i] = 8'($urandom);
            tick();
        end
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n_tests++;
        if (ir !== 3'b111 || ov !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset_flags: got ready %b valid %b want 111 000", ir, ov);
        end
`ifdef RV_ELASTIC_BUF_LEVEL_EN
        n_tests++;
        if (lv0 !== 2'd0 || lv1 !== 3'd0 || lv2 !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset_level: got %0d %0d %0d want 0 0 0", lv0, lv1, lv2);
        end
`endif
        iv    = 3'b100;
        id[2] = 8'hA5;
        tick();
        iv = '0;
        n_tests++;
        if (ov[2] !== 1'b1 || od2 !== 8'hA5) begin
            n_fail++;
            $display("FAIL post_reset_push: got valid %b data %h want 1 a5", ov[2], od2);
        end
        drain(3);
    endtask

    task automatic test_stream();
        int bpush;
        int bpop;
        idle();
        bpush  = pushes[0];
        bpop   = pops[0];
        orr[0] = 1'b1;
        for (int v = 0; v < 256; v++) begin
            iv[0] = 1'b1;
            id[0] = 8'(v);
            n_tests++;
            if (ir[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_in_ready beat %0d: got %b want 1", v, ir[0]);
            end
            tick();
        end
        iv[0] = 1'b0;
        n_tests++;
        if (pushes[0] - bpush != 256 || pops[0] - bpop != 255) begin
            n_fail++;
            $display("FAIL stream_rate: got push %0d pop %0d want 256 255", pushes[0] - bpush, pops[0] - bpop);
        end
        tick();
        n_tests++;
        if (pops[0] - bpop != 256) begin
            n_fail++;
            $display("FAIL stream_total: got %0d want 256", pops[0] - bpop);
        end
        idle();
    endtask

    task automatic test_fill();
        int bpush;
        int bpop;
        idle();
        bpush = pushes[1];
        bpop  = pops[1];
        for (int k = 0; k < 8; k++) begin
            iv[1] = 1'b1;
            id[1] = 8'(pushes[1] - bpush + 1);
            n_tests++;
            if (ir[1] !== (k < 5)) begin
                n_fail++;
                $display("FAIL fill_in_ready cycle %0d: got %b want %b", k, ir[1], k < 5);
            end
            tick();
        end
        n_tests++;
        if (pushes[1] - bpush != 5) begin
            n_fail++;
            $display("FAIL fill_accepted: got %0d want 5", pushes[1] - bpush);
        end
`ifdef RV_ELASTIC_BUF_LEVEL_EN
        n_tests++;
        if (lv1 !== 3'd5) begin
            n_fail++;
            $display("FAIL fill_level: got %0d want 5", lv1);
        end
`endif
        drain(6);
        n_tests++;
        if (pops[1] - bpop != 5) begin
            n_fail++;
            $display("FAIL fill_drained: got %0d want 5", pops[1] - bpop);
        end
    endtask

    task automatic test_full_pop();
        int bpush;
        int bpop;
        int p;
        idle();
        bpush = pushes[1];
        bpop  = pops[1];
        iv[1] = 1'b1;
        repeat (5) begin
            id[1] = 8'(8'h40 + pushes[1] - bpush);
            tick();
        end
        orr[1] = 1'b1;
        id[1]  = 8'(8'h40 + pushes[1] - bpush);
        n_tests++;
        if (ir[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL full_in_ready: got %b want 0", ir[1]);
        end
        p = pushes[1];
        tick();
        n_tests++;
        if (pushes[1] != p || ir[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_cycle: got push %0d ready %b want 0 1", pushes[1] - p, ir[1]);
        end
        repeat (10) begin
            id[1] = 8'(8'h40 + pushes[1] - bpush);
            tick();
        end
        drain(8);
        n_tests++;
        if (pushes[1] - bpush != pops[1] - bpop) begin
            n_fail++;
            $display("FAIL full_pop_balance: got push %0d pop %0d want equal", pushes[1] - bpush, pops[1] - bpop);
        end
    endtask

    task automatic test_wrap();
        int bpop;
        int cyc;
        logic       hold_prev;
        logic [7:0] prev;
        idle();
        bpop      = pops[2];
        cyc       = 0;
        hold_prev = 1'b0;
        prev      = '0;
        while (pops[2] - bpop < 10000 && cyc < 40000) begin
            iv[2]  = 1'($urandom_range(0, 1));
            orr[2] = 1'($urandom_range(0, 1));
            id[2]  = 8'($urandom);
            if (hold_prev) begin
                n_tests++;
                if (od2 !== prev) begin
                    n_fail++;
                    $display("FAIL wrap_stable cycle %0d: got %h want %h", cyc, od2, prev);
                end
            end
            hold_prev = ov[2] && !orr[2];
            prev      = od2;
            tick();
            cyc++;
        end
        n_tests++;
        if (pops[2] - bpop < 10000) begin
            n_fail++;
            $display("FAIL wrap_budget: got %0d beats want 10000", pops[2] - bpop);
        end
        drain(5);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < N; i++) begin
            hd[i]     = 0;
            tl[i]     = 0;
            pushes[i] = 0;
            pops[i]   = 0;
        end
        rst = 1'b1;
        idle();
        test_reset();
        test_stream();
        test_fill();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
